// File: rtl/alignment_output_buffer.sv
// alignment_output_buffer: LIFO that reverses traceback pairs and streams them out in forward order
module alignment_output_buffer #(
  parameter int N = 128,
  parameter int DEPTH = 2*N,
  parameter int score_lenght = $clog2(N+1),
  parameter int CntW = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_traceB,
  input  logic end_c,
  input  logic [2:0] datoA,
  input  logic [2:0] datoB,
  input  logic signed [score_lenght:0] final_score,
  output logic out_valid,
  input  logic out_ready,
  output logic [2:0] out_A,
  output logic [2:0] out_B,
  output logic out_last,
  output logic signed [score_lenght:0] out_score,
  output logic [CntW-1:0] align_len,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, LATCH = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [CntW-1:0] count;
  logic [5:0] mem [DEPTH];
  logic [AW-1:0] wa, ra;
  logic push, full, to_idle;
  assign full = count == CntW'(DEPTH);
  assign push = (state == IDLE || state == COLLECT) && en_traceB;
  assign to_idle = !en_traceB && ((state == COLLECT && !end_c) || state == DONE);
  assign wa = AW'(count);
  assign ra = AW'(count - CntW'(1));
  assign out_valid = state == DRAIN;
  assign out_last = out_valid && count == CntW'(1);
  assign {out_A, out_B} = out_valid ? mem[ra] : 6'd0;
  assign busy = state == COLLECT || state == LATCH || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (push && !full) mem[wa] <= {datoA, datoB};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      out_score <= '0;
      align_len <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && full) overflow <= 1'b1;
      if (push && !full) count <= count + CntW'(1);
      case (state)
        IDLE: if (en_traceB) state <= end_c ? LATCH : COLLECT;
        COLLECT: state <= end_c ? LATCH : (en_traceB ? COLLECT : IDLE);
        LATCH: begin
          out_score <= final_score;
          align_len <= count;
          state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          count <= count - CntW'(1);
          if (count == CntW'(1)) state <= DONE;
        end
        DONE: if (!en_traceB) state <= IDLE;
        default: state <= IDLE;
      endcase
      // leaving a run (abort or completion) wipes everything for the next collection
      if (to_idle) begin
        count <= '0;
        align_len <= '0;
        overflow <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alignment_output_buffer.sv
// tb_alignment_output_buffer: randomized checks against a queue-based reversal model
module tb_alignment_output_buffer;
  localparam int N = 128;
  localparam int DEPTH = 2*N;
  localparam int SW = $clog2(N+1) + 1;
  localparam int CntW = $clog2(DEPTH+1);
  logic clk = 0, rst = 0, en_traceB = 0, end_c = 0, out_ready = 0;
  logic [2:0] datoA = 0, datoB = 0;
  logic signed [SW-1:0] final_score = 0;
  logic out_valid, out_last, busy, done, overflow;
  logic [2:0] out_A, out_B;
  logic signed [SW-1:0] out_score;
  logic [CntW-1:0] align_len;
  int checks = 0, errors = 0;
  logic [2:0] tbl_a [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] tbl_b [4] = '{3'd1, 3'd4, 3'd3, 3'd0};

  alignment_output_buffer #(.N(N)) dut (
    .clk(clk), .rst(rst), .en_traceB(en_traceB), .end_c(end_c),
    .datoA(datoA), .datoB(datoB), .final_score(final_score),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_last(out_last), .out_score(out_score), .align_len(align_len),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input int n, input bit fin, input bit use_tbl, ref logic [5:0] q[$]);
    for (int i = 0; i < n; i++) begin
      en_traceB = 1;
      end_c = fin && (i == n-1);
      datoA = use_tbl ? tbl_a[i] : 3'($urandom);
      datoB = use_tbl ? tbl_b[i] : 3'($urandom);
      q.push_back({datoA, datoB});
      step();
    end
    en_traceB = 0;
    end_c = 0;
    datoA = 3'($urandom);
    datoB = 3'($urandom);
  endtask

  // expected output is the first min(n,DEPTH) pushes, read back newest first
  task automatic run(input int n, input logic signed [SW-1:0] sc, input bit rnd_ready, input bit use_tbl);
    logic [5:0] q[$];
    int m, idx, cyc;
    push_pairs(n, 1, use_tbl, q);
    final_score = sc;
    m = n > DEPTH ? DEPTH : n;
    chk("latch_valid", 32'(out_valid), 0);
    chk("latch_busy", 32'(busy), 1);
    step();
    final_score = SW'($urandom);
    chk("score", 32'(out_score), 32'(sc));
    chk("align_len", 32'(align_len), 32'(m));
    chk("overflow", 32'(overflow), 32'(n > DEPTH));
    idx = m - 1;
    cyc = 0;
    while (idx >= 0 && cyc < 4*m + 20) begin
      out_ready = rnd_ready ? 1'($urandom) : 1'b1;
      chk("valid", 32'(out_valid), 1);
      chk("out_A", 32'(out_A), 32'(q[idx][5:3]));
      chk("out_B", 32'(out_B), 32'(q[idx][2:0]));
      chk("last", 32'(out_last), 32'(idx == 0));
      step();
      if (out_ready) idx--;
      cyc++;
    end
    out_ready = 0;
    chk("drain_left", 32'(idx + 1), 0);
    if (!rnd_ready) chk("drain_cycles", 32'(cyc), 32'(m));
    chk("done", 32'(done), 1);
    chk("busy_after", 32'(busy), 0);
    chk("valid_after", 32'(out_valid), 0);
    chk("score_held", 32'(out_score), 32'(sc));
    step();
    chk("idle_done", 32'(done), 0);
    chk("idle_len", 32'(align_len), 0);
    chk("idle_ovf", 32'(overflow), 0);
  endtask

  initial begin
    logic [5:0] q[$];
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ab", 32'({out_A, out_B}), 0);
    chk("rst_score", 32'(out_score), 0);
    chk("rst_len", 32'(align_len), 0);
    chk("rst_flags", 32'({busy, done, overflow}), 0);
    rst = 1;
    step();
    run(4, 9'sd5, 0, 1);
    run(4, 9'sd5, 1, 1);
    run(1, -9'sd3, 0, 0);
    run(DEPTH + 2, 9'sd17, 0, 0);
    q.delete();
    push_pairs(3, 0, 0, q);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      step();
    end
    run(2, 9'sd2, 0, 0);
    for (int k = 0; k < 4; k++) run(int'($urandom_range(1, 40)), SW'($urandom), 1, 0);
    q.delete();
    push_pairs(5, 1, 0, q);
    final_score = 9'sd11;
    step();
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_score", 32'(out_score), 0);
    chk("mid_rst_ab", 32'({out_A, out_B, out_last}), 0);
    step();
    rst = 1;
    step();
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_valid", 32'(out_valid), 0);
    run(3, -9'sd7, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
